invaders_ram_arbiter: RTL and testbench
=======================================

Name: invaders_ram_arbiter

Overview:
- Shares the single-port 8 KB work/video RAM at 2000-3FFF between two requesters: the 8080 CPU bus and the video scanout fetcher.
- Sequences each access by driving the RAM's Ram_Addr, Ram_in and RW_n, capturing Ram_out after the RAM read latency, and returning data with an ack or valid pulse.
- Video has priority, but a wait counter bounds how long the CPU can be stalled.

Parameters:
- RD_LAT, 1: cycles from the RAM address-sample edge to the edge at which Ram_out is captured; range 1-3.
- CPU_WAIT_MAX, 4: when the CPU has waited this many cycles, it beats a pending video request.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- cpu_req  in  1  level; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  13  RAM offset (CPU address bits 12:0).
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid in the cpu_ack cycle and held until the next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  one-cycle fetch pulse; read only.
- vid_addr  in  13  RAM offset; sampled in the vid_req cycle.
- vid_rdata  out  8  fetch data; valid in the vid_valid cycle and held.
- vid_valid  out  1  one-cycle pulse.
- vid_overrun  out  1  sticky error flag; cleared only by Reset.
- Ram_Addr  out  16  {3'b001, offset}; registered.
- Ram_in  out  8  RAM write data; registered.
- RW_n  out  1  0 = write; registered.
- Ram_out  in  8  RAM read data (synchronous RAM).

Behaviour:
- Reset: all outputs 0 except RW_n = 1. State IDLE, vid_pend = 0, wait_cnt = 0. The next edge applies this from any state; an in-flight access is abandoned with no ack/valid, and RW_n is forced to 1.
- Video latch: a vid_req pulse loads vid_pend and vid_addr_q.
  - If vid_pend is already set and is not being granted this cycle, the new pulse is dropped and vid_overrun is set.
  - A pulse in the same cycle the pending request is granted becomes the new pending request; no overrun.
- wait_cnt: increments (saturating at CPU_WAIT_MAX) each cycle cpu_req = 1 and the CPU is not granted. Cleared on CPU grant.
- State machine: IDLE -> ACC -> LAT (RD_LAT cycles, reads only) -> IDLE.
- Arbitration (IDLE only), in priority order:
  1. CPU, if cpu_req = 1 and wait_cnt >= CPU_WAIT_MAX.
  2. Video, if vid_pend = 1 (or vid_req = 1 this cycle).
  3. CPU, if cpu_req = 1.
- cpu_req is ignored in any cycle where cpu_ack = 1; this prevents re-granting a completed request.
- Grant cycle G (IDLE): at the edge ending G, the arbiter registers Ram_Addr, Ram_in = cpu_wdata, and RW_n = ~cpu_we (CPU) or 1 (video). State -> ACC.
- ACC (G+1): the RAM samples at the end of G+1. RW_n returns to 1 at that edge.
  - Write: state -> IDLE, and cpu_ack = 1 during G+2.
  - Read: state -> LAT.
- LAT: at the end of the RD_LAT-th LAT cycle, Ram_out is captured into cpu_rdata or vid_rdata. cpu_ack or vid_valid is high in the following cycle, and state -> IDLE.
- Latencies:
  - Read with RD_LAT = 1: grant to ack/valid is 3 cycles (ack/valid in G+3).
  - Write: grant to ack is 2 cycles (ack in G+2).
- Issue rate: the IDLE/ack cycle can grant a new access, so back-to-back accesses run one read every 3 cycles.
- Only one access is in flight at a time. Ram_Addr holds its last value when idle.
- Simultaneous cpu_req and vid_req in IDLE with wait_cnt < CPU_WAIT_MAX: video wins, and the CPU waits.

Test Plan:
- Reset while in ACC of a CPU write (cpu_addr = 13'h0400): next cycle RW_n = 1, Ram_Addr = 0, state IDLE; no cpu_ack at any point; RAM word at 2400 unchanged if reset precedes the ACC edge.
- CPU write 8'hA5 to 13'h0123, then read of 13'h0123: Ram_Addr = 16'h2123 and RW_n = 0 for exactly one cycle; cpu_ack in G+2; read returns cpu_rdata = 8'hA5 with cpu_ack in G+3.
- vid_req with vid_addr = 13'h1FFF in the same cycle as cpu_req: video granted first (Ram_Addr = 16'h3FFF); vid_valid carries the RAM contents; CPU granted in the vid_valid cycle.
- Video vid_req every 3 cycles with cpu_req held high: CPU is granted at the first opportunity after wait_cnt reaches 4; video then resumes, and vid_overrun stays 0.
- Two vid_req pulses 1 cycle apart while a CPU read is in flight: the second pulse sets vid_overrun = 1; only the first fetch completes; the flag stays set until Reset.
- RD_LAT = 3 build: CPU read ack arrives in G+5; cpu_rdata equals the RAM contents; RW_n stays 1 throughout.

Source files
------------

// File: rtl/invaders_ram_arbiter.sv
// Arbiter for the shared 8 KB work/video RAM at 2000-3FFF.
// Two requesters share it: the 8080 CPU bus and the video fetcher.
// Video normally wins, but a CPU that has waited CPU_WAIT_MAX cycles takes
// the next slot. One access is in flight at a time: grant, ACC, optional
// LAT (reads only), then back to IDLE.
module invaders_ram_arbiter #(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CPU_WAIT_MAX = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [7:0]  vid_rdata,
    output logic        vid_valid,
    output logic        vid_overrun,
    output logic [15:0] Ram_Addr,
    output logic [7:0]  Ram_in,
    output logic        RW_n,
    input  logic [7:0]  Ram_out
);

    localparam int unsigned     WW       = $clog2(CPU_WAIT_MAX + 1);
    localparam logic [1:0]      LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [WW-1:0]   WAIT_LIM = WW'(CPU_WAIT_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, LAT = 2'd2} state_t;

    state_t         state, state_n;
    logic [1:0]     lat_cnt;
    logic [WW-1:0]  wait_cnt;
    logic           vid_pend;
    logic [12:0]    vid_addr_q;
    logic           cur_cpu;
    logic           cur_read;

    logic           cpu_eff;
    logic           cpu_hi;
    logic           vid_any;
    logic           grant_cpu;
    logic           grant_vid;
    logic           lat_done;
    logic           capture;
    logic [12:0]    vid_src;

    // State register and read-latency counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ACC)
                lat_cnt <= '0;
            else if (state == LAT)
                lat_cnt <= lat_cnt + 2'd1;
        end
    end

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_cpu || grant_vid) state_n = ACC;
            ACC:     state_n = cur_read ? LAT : IDLE;
            LAT:     if (lat_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Arbitration and capture decisions; a request is ignored in its own ack cycle
    always_comb begin
        cpu_eff   = cpu_req & ~cpu_ack;
        cpu_hi    = cpu_eff && (wait_cnt >= WAIT_LIM);
        vid_any   = vid_pend | vid_req;
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if (state == IDLE) begin
            grant_cpu = cpu_hi | (cpu_eff & ~vid_any);
            grant_vid = ~cpu_hi & vid_any;
        end
        vid_src  = vid_pend ? vid_addr_q : vid_addr;
        lat_done = (lat_cnt == LAT_LAST);
        capture  = (state == LAT) && lat_done;
    end

    // RAM port registers, read-data capture and completion pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Ram_Addr  <= '0;
            Ram_in    <= '0;
            RW_n      <= 1'b1;
            cpu_rdata <= '0;
            vid_rdata <= '0;
            cpu_ack   <= 1'b0;
            vid_valid <= 1'b0;
            cur_cpu   <= 1'b0;
            cur_read  <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            vid_valid <= 1'b0;
            if (grant_cpu) begin
                Ram_Addr <= {3'b001, cpu_addr};
                Ram_in   <= cpu_wdata;
                RW_n     <= ~cpu_we;
                cur_cpu  <= 1'b1;
                cur_read <= ~cpu_we;
            end else if (grant_vid) begin
                Ram_Addr <= {3'b001, vid_src};
                RW_n     <= 1'b1;
                cur_cpu  <= 1'b0;
                cur_read <= 1'b1;
            end
            if (state == ACC) begin
                RW_n <= 1'b1;
                if (!cur_read)
                    cpu_ack <= 1'b1;
            end
            if (capture) begin
                if (cur_cpu) begin
                    cpu_rdata <= Ram_out;
                    cpu_ack   <= 1'b1;
                end else begin
                    vid_rdata <= Ram_out;
                    vid_valid <= 1'b1;
                end
            end
        end
    end

    // Single-entry video request latch with sticky overrun flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vid_pend    <= 1'b0;
            vid_addr_q  <= '0;
            vid_overrun <= 1'b0;
        end else begin
            if (grant_vid)
                vid_pend <= 1'b0;
            if (vid_req) begin
                // A pulse granted straight through (nothing pending) is not latched;
                // a pulse alongside a granted pending request replaces it.
                if (vid_pend && !grant_vid) begin
                    vid_overrun <= 1'b1;
                end else if (vid_pend || !grant_vid) begin
                    vid_pend   <= 1'b1;
                    vid_addr_q <= vid_addr;
                end
            end
        end
    end

    // CPU wait counter, saturating, cleared on CPU grant
    always_ff @(posedge Clock) begin
        if (Reset)
            wait_cnt <= '0;
        else if (grant_cpu)
            wait_cnt <= '0;
        else if (cpu_eff && (wait_cnt < WAIT_LIM))
            wait_cnt <= wait_cnt + WW'(1);
    end

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// Bench for invaders_ram_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a timeline model of the access schedule.
module tb_invaders_ram_arbiter;

    localparam int unsigned RD_LAT = 1;
    localparam int          WMAX   = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic [7:0]  cpu_rdata, vid_rdata, Ram_in, Ram_out;
    logic        cpu_ack, vid_valid, vid_overrun, RW_n;
    logic [15:0] Ram_Addr;

    invaders_ram_arbiter #(.RD_LAT(RD_LAT), .CPU_WAIT_MAX(WMAX)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .Ram_Addr(Ram_Addr), .Ram_in(Ram_in), .RW_n(RW_n), .Ram_out(Ram_out)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM environment: unwritten words return a seeded pattern
    logic [7:0] salt;
    logic [7:0] ram_env [8192];
    bit         ram_wr  [8192];
    logic [7:0] ram_q = '0;
    bit         ram_en = 1'b0;
    assign Ram_out = ram_q;

    function automatic logic [7:0] init_val(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b000} ^ salt;
    endfunction

    always @(posedge Clock) begin
        if (ram_en && !RW_n) begin
            ram_env[Ram_Addr[12:0]] <= Ram_in;
            ram_wr[Ram_Addr[12:0]]  <= 1'b1;
        end
        ram_q <= ram_wr[Ram_Addr[12:0]] ? ram_env[Ram_Addr[12:0]] : init_val(Ram_Addr[12:0]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: timeline of the single in-flight job plus request bookkeeping
    int          t = 0;
    bit          job = 0, j_cpu = 0, j_read = 0;
    int          j_g = 0, j_done = 0;
    logic [12:0] j_addr = '0;
    bit          m_pend = 0, m_ovr = 0;
    logic [12:0] m_vq = '0;
    int          m_wait = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_in = '0, m_crd = '0, m_vrd = '0;
    logic [7:0]  mem_m [8192];
    bit          e_ack = 0, e_valid = 0, e_rwn = 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic void model_expect();
        e_ack   = job && j_cpu && (t == j_done);
        e_valid = job && !j_cpu && (t == j_done);
        e_rwn   = !(job && !j_read && (t == j_g + 1));
        if (job && j_read && (t == j_done)) begin
            if (j_cpu) m_crd = mem_m[j_addr];
            else       m_vrd = mem_m[j_addr];
        end
    endfunction

    function automatic void model_update();
        bit ceff, idle, hi, vany, gc, gv, old_p;
        logic [12:0] src;
        if (Reset) begin
            job = 0; m_pend = 0; m_ovr = 0; m_wait = 0;
            m_addr = '0; m_in = '0; m_crd = '0; m_vrd = '0; m_vq = '0;
            return;
        end
        ceff = cpu_req && !e_ack;
        idle = !job || (t >= j_done);
        if (idle) job = 0;
        hi   = ceff && (m_wait >= WMAX);
        vany = m_pend || vid_req;
        gc   = idle && (hi || (ceff && !vany));
        gv   = idle && !hi && vany;
        src  = m_pend ? m_vq : vid_addr;
        if (gc) begin
            job = 1; j_cpu = 1; j_read = !cpu_we; j_g = t; j_addr = cpu_addr;
            m_addr = {3'b001, cpu_addr};
            m_in   = cpu_wdata;
            j_done = t + 2 + (cpu_we ? 0 : int'(RD_LAT));
            if (cpu_we) mem_m[cpu_addr] = cpu_wdata;
        end
        if (gv) begin
            job = 1; j_cpu = 0; j_read = 1; j_g = t; j_addr = src;
            m_addr = {3'b001, src};
            j_done = t + 2 + int'(RD_LAT);
        end
        old_p = m_pend;
        if (gv) m_pend = 0;
        if (vid_req) begin
            if (old_p && !gv) m_ovr = 1;
            else if (old_p || !gv) begin
                m_pend = 1;
                m_vq   = vid_addr;
            end
        end
        if (gc) m_wait = 0;
        else if (ceff && m_wait < WMAX) m_wait++;
    endfunction

    // One clock: advance model with current inputs, then compare the new cycle
    task automatic step();
        model_update();
        @(posedge Clock);
        #1;
        t++;
        model_expect();
        check("cpu_ack",     16'(cpu_ack),     16'(e_ack));
        check("vid_valid",   16'(vid_valid),   16'(e_valid));
        check("RW_n",        16'(RW_n),        16'(e_rwn));
        check("Ram_Addr",    Ram_Addr,         m_addr);
        check("cpu_rdata",   16'(cpu_rdata),   16'(m_crd));
        check("vid_rdata",   16'(vid_rdata),   16'(m_vrd));
        check("vid_overrun", 16'(vid_overrun), 16'(m_ovr));
        if (!e_rwn) check("Ram_in", 16'(Ram_in), 16'(m_in));
        vid_req = 1'b0;
        if (e_ack) cpu_req = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] d, output int lat);
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0;
        while (cpu_req && lat < 40) begin
            step();
            lat++;
        end
        check("cpu_op_done", 16'(cpu_req), 16'd0);
    endtask

    initial begin
        int lat, vcnt, acks;
        logic [7:0] saved;
        salt = 8'($urandom);
        for (int i = 0; i < 8192; i++) mem_m[i] = init_val(13'(i));

        // Reset state
        Reset = 1'b1;
        step();
        ram_en = 1'b1;
        step();
        Reset = 1'b0;
        run_idle(2);

        // Write then read back
        cpu_op(1'b1, 13'h0123, 8'hA5, lat);
        check("wr_latency", 16'(lat), 16'd2);
        cpu_op(1'b0, 13'h0123, 8'h00, lat);
        check("rd_latency", 16'(lat), 16'(2 + RD_LAT));
        check("rd_data", 16'(cpu_rdata), 16'h00A5);

        // Simultaneous CPU and video request: video first, CPU in vid_valid cycle
        run_idle(3);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        vid_req = 1'b1; vid_addr = 13'h1FFF;
        lat = 0; vcnt = 0;
        while (cpu_req && lat < 40) begin
            step();
            lat++;
            if (vid_valid) begin
                vcnt++;
                check("sim_vdata", 16'(vid_rdata), 16'(mem_m[13'h1FFF]));
            end
        end
        check("sim_vid_first", 16'(vcnt), 16'd1);
        check("sim_cpu_latency", 16'(lat), 16'(2 * (2 + RD_LAT)));

        // Video every 3 cycles while CPU is held: bounded wait, no overrun
        run_idle(3);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            vid_req  = (i % 3 == 0);
            vid_addr = 13'($urandom);
            step();
            if (cpu_ack) acks++;
        end
        check("starve_cpu_served", 16'(acks), 16'd1);
        check("starve_no_overrun", 16'(vid_overrun), 16'd0);

        // Two video pulses while a CPU read is in flight
        run_idle(6);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0055;
        step();
        vid_req = 1'b1; vid_addr = 13'h0100;
        step();
        vid_req = 1'b1; vid_addr = 13'h0200;
        step();
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vid_valid) vcnt++;
        end
        check("ovr_one_fetch", 16'(vcnt), 16'd1);
        check("ovr_fetch_data", 16'(vid_rdata), 16'(mem_m[13'h0100]));
        check("ovr_flag", 16'(vid_overrun), 16'd1);
        run_idle(10);
        check("ovr_sticky", 16'(vid_overrun), 16'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("ovr_cleared", 16'(vid_overrun), 16'd0);

        // Reset coinciding with a write grant: write never happens
        run_idle(2);
        saved = mem_m[13'h0400];
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = ~saved;
        Reset = 1'b1;
        step();
        cpu_req = 1'b0;
        Reset = 1'b0;
        run_idle(3);
        cpu_op(1'b0, 13'h0400, 8'h00, lat);
        check("rst_grant_nowrite", 16'(cpu_rdata), 16'(saved));

        // Reset during ACC of a CPU write: no ack, RW_n released, address cleared
        run_idle(2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = 8'h3C;
        step();
        check("acc_rw_low", 16'(RW_n), 16'd0);
        Reset = 1'b1;
        cpu_req = 1'b0;
        step();
        Reset = 1'b0;
        check("rst_rwn", 16'(RW_n), 16'd1);
        check("rst_addr", Ram_Addr, 16'h0000);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ack) acks++;
        end
        check("rst_no_ack", 16'(acks), 16'd0);

        // Random traffic, small address window so reads hit earlier writes
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom);
                cpu_addr  = 13'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 13'h1FE0 : 13'h0000);
                cpu_wdata = 8'($urandom);
            end
            vid_req  = ($urandom_range(0, 3) == 0);
            vid_addr = 13'($urandom_range(0, 31));
            step();
        end
        Reset = 1'b0;
        cpu_req = 1'b0;
        run_idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
